// File: rtl/vx_commit_collector_pkg.sv
// Shared types and widths for the commit collector.
// Commit packet layout plus a lane popcount helper.
package vx_commit_collector_pkg;
  localparam int NUM_EX_UNITS = 4;
  localparam int NUM_LANES = 4;
  localparam int NW_BITS = 3;
  localparam int XLEN = 32;
  localparam int NR_BITS = 5;
  localparam int PC_BITS = 32;
  localparam int UIDX_W = $clog2(NUM_EX_UNITS);
  localparam int DATA_W = NUM_LANES * XLEN;

  typedef struct packed {
    logic [NW_BITS-1:0]   wid;
    logic [NUM_LANES-1:0] tmask;
    logic [PC_BITS-1:0]   pc;
    logic                 wb;
    logic [NR_BITS-1:0]   rd;
    logic [DATA_W-1:0]    data;
    logic                 sop;
    logic                 eop;
  } commit_t;

  function automatic logic [63:0] popcount(
    input logic [NUM_LANES-1:0] m
  );
    logic [63:0] c;
    c = '0;
    for (int i = 0; i < NUM_LANES; i++)
      c = c + 64'(m[i]);
    return c;
  endfunction
endpackage

// File: rtl/vx_commit_collector_if.sv
// Per-unit commit stream bundle, flattened by unit.
// master = execute units, slave = collector.
interface vx_commit_collector_if;
  import vx_commit_collector_pkg::*;

  logic [NUM_EX_UNITS-1:0]           commit_valid;
  logic [NUM_EX_UNITS-1:0]           commit_ready;
  logic [NUM_EX_UNITS*NW_BITS-1:0]   commit_wid;
  logic [NUM_EX_UNITS*NUM_LANES-1:0] commit_tmask;
  logic [NUM_EX_UNITS*PC_BITS-1:0]   commit_pc;
  logic [NUM_EX_UNITS-1:0]           commit_wb;
  logic [NUM_EX_UNITS*NR_BITS-1:0]   commit_rd;
  logic [NUM_EX_UNITS*DATA_W-1:0]    commit_data;
  logic [NUM_EX_UNITS-1:0]           commit_sop;
  logic [NUM_EX_UNITS-1:0]           commit_eop;

  modport master (
    output commit_valid, commit_wid,
    output commit_tmask, commit_pc,
    output commit_wb, commit_rd,
    output commit_data,
    output commit_sop, commit_eop,
    input  commit_ready
  );

  modport slave (
    input  commit_valid, commit_wid,
    input  commit_tmask, commit_pc,
    input  commit_wb, commit_rd,
    input  commit_data,
    input  commit_sop, commit_eop,
    output commit_ready
  );
endinterface

// File: rtl/vx_commit_collector_arbiter.sv
// Round-robin arbiter with an external lock.
// While locked only the locked requester may win.
module vx_rr_lock_arbiter #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] start_i,
  input  logic          lock_i,
  input  logic [IW-1:0] lock_idx_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] gnt_idx_o,
  output logic          gnt_valid_o
);
  function automatic logic [IW-1:0] rot(
    input logic [IW-1:0] s,
    input int k
  );
    int t;
    t = int'(s) + k;
    if (t >= N) t = t - N;
    return IW'(t);
  endfunction

  // Scan from the far end so the nearest one wins.
  always_comb begin
    gnt_o       = '0;
    gnt_idx_o   = '0;
    gnt_valid_o = 1'b0;
    if (lock_i) begin
      gnt_valid_o = req_i[lock_idx_i];
      gnt_idx_o   = lock_idx_i;
    end else begin
      for (int k = N - 1; k >= 0; k--) begin
        if (req_i[rot(start_i, k)]) begin
          gnt_valid_o = 1'b1;
          gnt_idx_o   = rot(start_i, k);
        end
      end
    end
    if (gnt_valid_o) gnt_o[gnt_idx_o] = 1'b1;
  end
endmodule

// File: rtl/vx_commit_collector.sv
// Commit collector: arbitrates unit commits into
// a registered writeback, retire pulse and instret.
module vx_commit_collector
  import vx_commit_collector_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  vx_commit_collector_if.slave cif,
  output logic                 wb_valid,
  output logic [NW_BITS-1:0]   wb_wid,
  output logic [NR_BITS-1:0]   wb_rd,
  output logic [NUM_LANES-1:0] wb_tmask,
  output logic [DATA_W-1:0]    wb_data,
  output logic                 retire_valid,
  output logic [NW_BITS-1:0]   retire_wid,
  output logic [PC_BITS-1:0]   retire_pc,
  output logic [63:0]          instret
);
  commit_t pkt [NUM_EX_UNITS];
  commit_t sel;
  logic [NUM_EX_UNITS-1:0] gnt;
  logic [UIDX_W-1:0] gnt_idx;
  logic fire;

  logic lock_q, lock_d;
  logic [UIDX_W-1:0] lock_idx_q, lock_idx_d;
  logic [UIDX_W-1:0] ptr_q, ptr_d;
  logic wbv_q, wbv_d;
  logic [NW_BITS-1:0] wwid_q, wwid_d;
  logic [NR_BITS-1:0] wrd_q, wrd_d;
  logic [NUM_LANES-1:0] wtm_q, wtm_d;
  logic [DATA_W-1:0] wdat_q, wdat_d;
  logic retv_q, retv_d;
  logic [NW_BITS-1:0] rwid_q, rwid_d;
  logic [PC_BITS-1:0] rpc_q, rpc_d;
  logic [63:0] instret_q, instret_d;

  always_comb begin
    for (int u = 0; u < NUM_EX_UNITS; u++) begin
      pkt[u].wid   = cif.commit_wid[u*NW_BITS +: NW_BITS];
      pkt[u].tmask = cif.commit_tmask[u*NUM_LANES +: NUM_LANES];
      pkt[u].pc    = cif.commit_pc[u*PC_BITS +: PC_BITS];
      pkt[u].wb    = cif.commit_wb[u];
      pkt[u].rd    = cif.commit_rd[u*NR_BITS +: NR_BITS];
      pkt[u].data  = cif.commit_data[u*DATA_W +: DATA_W];
      pkt[u].sop   = cif.commit_sop[u];
      pkt[u].eop   = cif.commit_eop[u];
    end
  end

  vx_rr_lock_arbiter #(
    .N  (NUM_EX_UNITS),
    .IW (UIDX_W)
  ) u_arb (
    .req_i       (cif.commit_valid),
    .start_i     (ptr_q),
    .lock_i      (lock_q),
    .lock_idx_i  (lock_idx_q),
    .gnt_o       (gnt),
    .gnt_idx_o   (gnt_idx),
    .gnt_valid_o (fire)
  );

  assign cif.commit_ready = gnt;
  assign sel = pkt[gnt_idx];

  always_comb begin
    lock_d     = lock_q;
    lock_idx_d = lock_idx_q;
    ptr_d      = ptr_q;
    wbv_d      = 1'b0;
    wwid_d     = wwid_q;
    wrd_d      = wrd_q;
    wtm_d      = wtm_q;
    wdat_d     = wdat_q;
    retv_d     = 1'b0;
    rwid_d     = rwid_q;
    rpc_d      = rpc_q;
    instret_d  = instret_q;
    if (fire) begin
      wbv_d  = sel.wb & (|sel.tmask);
      wwid_d = sel.wid;
      wrd_d  = sel.rd;
      wtm_d  = sel.tmask;
      wdat_d = sel.data;
      if (sel.eop) begin
        lock_d    = 1'b0;
        ptr_d     = (gnt_idx == UIDX_W'(NUM_EX_UNITS - 1))
                    ? '0 : gnt_idx + 1'b1;
        retv_d    = 1'b1;
        rwid_d    = sel.wid;
        rpc_d     = sel.pc;
        instret_d = instret_q + popcount(sel.tmask);
      end else if (sel.sop) begin
        lock_d     = 1'b1;
        lock_idx_d = gnt_idx;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
      ptr_q      <= '0;
      wbv_q      <= 1'b0;
      wwid_q     <= '0;
      wrd_q      <= '0;
      wtm_q      <= '0;
      wdat_q     <= '0;
      retv_q     <= 1'b0;
      rwid_q     <= '0;
      rpc_q      <= '0;
      instret_q  <= '0;
    end else begin
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
      ptr_q      <= ptr_d;
      wbv_q      <= wbv_d;
      wwid_q     <= wwid_d;
      wrd_q      <= wrd_d;
      wtm_q      <= wtm_d;
      wdat_q     <= wdat_d;
      retv_q     <= retv_d;
      rwid_q     <= rwid_d;
      rpc_q      <= rpc_d;
      instret_q  <= instret_d;
    end
  end

  assign wb_valid     = wbv_q;
  assign wb_wid       = wwid_q;
  assign wb_rd        = wrd_q;
  assign wb_tmask     = wtm_q;
  assign wb_data      = wdat_q;
  assign retire_valid = retv_q;
  assign retire_wid   = rwid_q;
  assign retire_pc    = rpc_q;
  assign instret      = instret_q;
endmodule

// File: tb/tb_vx_commit_collector.sv
// Bench for vx_commit_collector: vector table,
// directed lock/reset/wrap sequences, random vs model.
module tb_vx_commit_collector;
  import vx_commit_collector_pkg::*;
  localparam int N = NUM_EX_UNITS;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  vx_commit_collector_if cif();

  logic                 wb_valid;
  logic [NW_BITS-1:0]   wb_wid;
  logic [NR_BITS-1:0]   wb_rd;
  logic [NUM_LANES-1:0] wb_tmask;
  logic [DATA_W-1:0]    wb_data;
  logic                 retire_valid;
  logic [NW_BITS-1:0]   retire_wid;
  logic [PC_BITS-1:0]   retire_pc;
  logic [63:0]          instret;

  vx_commit_collector dut (
    .clk          (clk),
    .reset        (reset),
    .cif          (cif),
    .wb_valid     (wb_valid),
    .wb_wid       (wb_wid),
    .wb_rd        (wb_rd),
    .wb_tmask     (wb_tmask),
    .wb_data      (wb_data),
    .retire_valid (retire_valid),
    .retire_wid   (retire_wid),
    .retire_pc    (retire_pc),
    .instret      (instret)
  );

  commit_t pk [N];
  logic [N-1:0] vld = '0;

  always_comb begin
    cif.commit_valid = vld;
    cif.commit_wid   = '0;
    cif.commit_tmask = '0;
    cif.commit_pc    = '0;
    cif.commit_wb    = '0;
    cif.commit_rd    = '0;
    cif.commit_data  = '0;
    cif.commit_sop   = '0;
    cif.commit_eop   = '0;
    for (int u = 0; u < N; u++) begin
      cif.commit_wid[u*NW_BITS +: NW_BITS]       = pk[u].wid;
      cif.commit_tmask[u*NUM_LANES +: NUM_LANES] = pk[u].tmask;
      cif.commit_pc[u*PC_BITS +: PC_BITS]        = pk[u].pc;
      cif.commit_wb[u]                           = pk[u].wb;
      cif.commit_rd[u*NR_BITS +: NR_BITS]        = pk[u].rd;
      cif.commit_data[u*DATA_W +: DATA_W]        = pk[u].data;
      cif.commit_sop[u]                          = pk[u].sop;
      cif.commit_eop[u]                          = pk[u].eop;
    end
  end

  int errs = 0;
  int checks = 0;

  task automatic chk(input string nm,
                     input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic commit_t mk(
    input logic [NW_BITS-1:0] w,
    input logic [NUM_LANES-1:0] t,
    input logic [PC_BITS-1:0] p,
    input logic b,
    input logic [NR_BITS-1:0] r,
    input logic [DATA_W-1:0] d,
    input logic s,
    input logic e
  );
    commit_t c;
    c.wid = w; c.tmask = t; c.pc = p; c.wb = b;
    c.rd = r; c.data = d; c.sop = s; c.eop = e;
    return c;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    #2;
    reset = 1'b1;
    tick();
  endtask

  typedef struct {
    int                   unit;
    logic [NW_BITS-1:0]   wid;
    logic [NR_BITS-1:0]   rd;
    logic [NUM_LANES-1:0] tm;
    logic                 wb;
    logic [PC_BITS-1:0]   pc;
    logic [N-1:0]         e_rdy;
    logic                 e_wbv;
    logic [63:0]          e_inst;
  } vec_t;

  vec_t vt [5];

  task automatic run_random(input int n);
    int rem [N];
    int g;
    int len;
    logic s;
    commit_t p;
    commit_t e;
    logic e_wbv, e_ret;
    logic [N-1:0] e_rdy;
    logic m_lock;
    int m_lu, m_start;
    logic [63:0] m_inst;
    m_lock = 1'b0; m_lu = 0; m_start = 0; m_inst = '0;
    e = '0;
    for (int u = 0; u < N; u++) rem[u] = 0;
    for (int cyc = 0; cyc < n; cyc++) begin
      for (int u = 0; u < N; u++) begin
        if (!vld[u] && $urandom_range(1, 0) == 1) begin
          s = 1'b0;
          if (rem[u] == 0) begin
            len = $urandom_range(3, 1);
            rem[u] = len;
            s = 1'b1;
          end
          pk[u] = mk(NW_BITS'($urandom),
                     NUM_LANES'($urandom_range(15, 0)),
                     $urandom, 1'($urandom),
                     NR_BITS'($urandom),
                     {$urandom, $urandom, $urandom, $urandom},
                     s, rem[u] == 1);
          rem[u]--;
          vld[u] = 1'b1;
        end
      end
      g = -1;
      if (m_lock) begin
        if (vld[m_lu]) g = m_lu;
      end else begin
        for (int k = 0; k < N; k++) begin
          if (g < 0 && vld[(m_start + k) % N]) g = (m_start + k) % N;
        end
      end
      e_rdy = '0;
      e_wbv = 1'b0;
      e_ret = 1'b0;
      if (g >= 0) begin
        e_rdy[g] = 1'b1;
        p = pk[g];
        e = p;
        e_wbv = p.wb && (p.tmask != 0);
        e_ret = p.eop;
        if (p.eop) begin
          m_inst  = m_inst + 64'($countones(p.tmask));
          m_start = (g + 1) % N;
          m_lock  = 1'b0;
        end else if (p.sop) begin
          m_lock = 1'b1;
          m_lu   = g;
        end
      end
      #1;
      chk("rnd_ready", 128'(cif.commit_ready), 128'(e_rdy));
      tick();
      if (g >= 0) vld[g] = 1'b0;
      chk("rnd_wb_valid", 128'(wb_valid), 128'(e_wbv));
      if (e_wbv) begin
        chk("rnd_wb_rd", 128'(wb_rd), 128'(e.rd));
        chk("rnd_wb_wid", 128'(wb_wid), 128'(e.wid));
        chk("rnd_wb_tmask", 128'(wb_tmask), 128'(e.tmask));
        chk("rnd_wb_data", wb_data, e.data);
      end
      chk("rnd_retire", 128'(retire_valid), 128'(e_ret));
      if (e_ret) begin
        chk("rnd_ret_wid", 128'(retire_wid), 128'(e.wid));
        chk("rnd_ret_pc", 128'(retire_pc), 128'(e.pc));
      end
      chk("rnd_instret", 128'(instret), 128'(m_inst));
    end
    vld = '0;
  endtask

  logic [NUM_LANES-1:0] ftm [N];
  logic [DATA_W-1:0] d;

  initial begin
    for (int u = 0; u < N; u++) pk[u] = '0;
    vt[0] = '{1, 3'd2, 5'd5, 4'b1011, 1'b1, 32'h100, 4'b0010, 1'b1, 64'd3};
    vt[1] = '{0, 3'd1, 5'd7, 4'b1111, 1'b0, 32'h200, 4'b0001, 1'b0, 64'd7};
    vt[2] = '{3, 3'd5, 5'd1, 4'b0000, 1'b1, 32'h300, 4'b1000, 1'b0, 64'd7};
    vt[3] = '{2, 3'd7, 5'd31, 4'b0110, 1'b1, 32'h400, 4'b0100, 1'b1, 64'd9};
    vt[4] = '{1, 3'd0, 5'd0, 4'b0001, 1'b1, 32'h500, 4'b0010, 1'b1, 64'd10};
    ftm[0] = 4'b1111; ftm[1] = 4'b0011;
    ftm[2] = 4'b0001; ftm[3] = 4'b0111;

    #1 reset = 1'b0;
    #1;
    chk("rst_wb_valid", 128'(wb_valid), 128'(0));
    chk("rst_retire", 128'(retire_valid), 128'(0));
    chk("rst_instret", 128'(instret), 128'(0));
    chk("rst_ready", 128'(cif.commit_ready), 128'(0));
    @(negedge clk) reset = 1'b1;
    tick();

    for (int i = 0; i < 5; i++) begin
      d = {4{vt[i].pc ^ 32'hA5A5_0000}};
      pk[vt[i].unit] = mk(vt[i].wid, vt[i].tm, vt[i].pc,
                          vt[i].wb, vt[i].rd, d, 1'b1, 1'b1);
      vld = '0;
      vld[vt[i].unit] = 1'b1;
      #1;
      chk("vec_ready", 128'(cif.commit_ready), 128'(vt[i].e_rdy));
      tick();
      vld = '0;
      chk("vec_wb_valid", 128'(wb_valid), 128'(vt[i].e_wbv));
      if (vt[i].e_wbv) begin
        chk("vec_wb_rd", 128'(wb_rd), 128'(vt[i].rd));
        chk("vec_wb_wid", 128'(wb_wid), 128'(vt[i].wid));
        chk("vec_wb_tmask", 128'(wb_tmask), 128'(vt[i].tm));
        chk("vec_wb_data", wb_data, d);
      end
      chk("vec_retire", 128'(retire_valid), 128'(1));
      chk("vec_ret_wid", 128'(retire_wid), 128'(vt[i].wid));
      chk("vec_ret_pc", 128'(retire_pc), 128'(vt[i].pc));
      chk("vec_instret", 128'(instret), 128'(vt[i].e_inst));
    end
    tick();
    chk("idle_retire", 128'(retire_valid), 128'(0));
    chk("idle_wb_valid", 128'(wb_valid), 128'(0));

    pulse_reset();
    for (int k = 0; k < 8; k++) begin
      for (int u = 0; u < N; u++)
        pk[u] = mk(NW_BITS'(u), ftm[u], 32'(u), 1'b1,
                   5'd3, '0, 1'b1, 1'b1);
      vld = '1;
      #1;
      chk("fair_ready", 128'(cif.commit_ready), 128'(1 << (k % 4)));
      tick();
      chk("fair_ret_wid", 128'(retire_wid), 128'(k % 4));
    end
    vld = '0;
    chk("fair_instret", 128'(instret), 128'(20));

    pk[2] = mk(3'd3, 4'b1111, 32'h40, 1'b1, 5'd9, '1, 1'b1, 1'b0);
    vld = 4'b0100;
    #1 chk("lockA_ready", 128'(cif.commit_ready), 128'(4'b0100));
    tick();
    chk("lockA_retire", 128'(retire_valid), 128'(0));
    pk[2] = mk(3'd3, 4'b0011, 32'h40, 1'b1, 5'd9, '1, 1'b0, 1'b0);
    pk[0] = mk(3'd1, 4'b0001, 32'h80, 1'b1, 5'd2, '0, 1'b1, 1'b1);
    vld = 4'b0101;
    #1 chk("lockB_ready", 128'(cif.commit_ready), 128'(4'b0100));
    tick();
    chk("lockB_retire", 128'(retire_valid), 128'(0));
    pk[2] = mk(3'd3, 4'b0111, 32'h40, 1'b1, 5'd9, '1, 1'b0, 1'b1);
    #1 chk("lockC_ready", 128'(cif.commit_ready), 128'(4'b0100));
    tick();
    chk("lockC_retire", 128'(retire_valid), 128'(1));
    chk("lockC_ret_wid", 128'(retire_wid), 128'(3));
    chk("lockC_instret", 128'(instret), 128'(23));
    vld = 4'b0001;
    #1 chk("lockD_ready", 128'(cif.commit_ready), 128'(4'b0001));
    tick();
    vld = '0;
    chk("lockD_ret_wid", 128'(retire_wid), 128'(1));
    chk("lockD_instret", 128'(instret), 128'(24));

    force dut.instret_q = 64'hFFFF_FFFF_FFFF_FFFE;
    #1 release dut.instret_q;
    pk[3] = mk(3'd4, 4'b1111, 32'h90, 1'b1, 5'd4, '0, 1'b1, 1'b1);
    vld = 4'b1000;
    tick();
    vld = '0;
    chk("wrap_instret", 128'(instret), 128'(2));

    pk[2] = mk(3'd2, 4'b1111, 32'hA0, 1'b1, 5'd6, '1, 1'b1, 1'b0);
    vld = 4'b0100;
    tick();
    vld = '0;
    #1 reset = 1'b0;
    #1;
    chk("arst_wb_valid", 128'(wb_valid), 128'(0));
    chk("arst_wb_tmask", 128'(wb_tmask), 128'(0));
    chk("arst_retire", 128'(retire_valid), 128'(0));
    chk("arst_instret", 128'(instret), 128'(0));
    #1 reset = 1'b1;
    pk[3] = mk(3'd6, 4'b0101, 32'h77, 1'b1, 5'd8, '0, 1'b1, 1'b1);
    vld = 4'b1000;
    #1 chk("arst_ready", 128'(cif.commit_ready), 128'(4'b1000));
    tick();
    vld = '0;
    chk("arst_retire2", 128'(retire_valid), 128'(1));
    chk("arst_ret_wid", 128'(retire_wid), 128'(6));
    chk("arst_instret2", 128'(instret), 128'(2));

    pulse_reset();
    run_random(600);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
